i2c_arbiter_n: RTL and testbench

- Parametrised N-master arbiter for the single shared I2C bus.
- Generalises the existing two-master arbiter (EEPROM/OLED) to N requesters.
- Selectable fixed-priority or round-robin arbitration.
- Ownership is held until the owner drops its request; a mandatory idle turnaround cycle separates owners.
- Sits between the I2C master front-ends (EEPROM, OLED, future sensors) and the bus mux driven by master_sel.

---
 rtl/i2c_arbiter_n.sv | 138 +++++++++++++
 tb/tb_i2c_arbiter_n.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter_n.sv
// i2c_arbiter_n: N-master arbiter for the shared I2C bus, fixed-priority
// or round-robin, with ownership held until the owner drops its request.
// Ports: clk, reset (async, active-high), req[N_MASTERS], grant[N_MASTERS],
//        master_sel[SEL_W] (0 = idle, i+1 = master i), busy, timeout.
// Optional macro I2C_ARB_TIMEOUT_EN adds a grant-length watchdog that
// revokes and masks an owner after TIMEOUT_CYCLES cycles; else timeout = 0.
module i2c_arbiter_n #(
    parameter int N_MASTERS      = 4,
    parameter int SEL_W          = 3,
    parameter int RR_MODE        = 0,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] grant,
    output logic [SEL_W-1:0]     master_sel,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    if ((1 << SEL_W) <= N_MASTERS) begin : g_bad_sel
        $error("SEL_W too narrow for N_MASTERS");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must fit a 16-bit counter");
    end

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     rr_ptr;
    logic [N_MASTERS-1:0] elig;
    logic                 found;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     scan_idx;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0]          wd_cnt;
    logic [N_MASTERS-1:0] mask;

    // A revoked master stays ineligible until it lets go of req.
    assign elig = req & ~mask;
`else
    assign elig    = req;
    assign timeout = 1'b0;
`endif

    // Scan order: index 0 upward, or starting just after the last winner.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (RR_MODE != 0) begin
                scan_idx = IDX_W'((int'(rr_ptr) + 1 + k) % N_MASTERS);
            end else begin
                scan_idx = IDX_W'(k);
            end
            if (!found && elig[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= '0;
            rr_ptr     <= IDX_W'(N_MASTERS - 1);
            grant      <= '0;
            master_sel <= '0;
            busy       <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_cnt     <= '0;
            mask       <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
`ifdef I2C_ARB_TIMEOUT_EN
            timeout <= 1'b0;
            mask    <= mask & req;
`endif
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        state      <= S_OWN;
                        owner      <= winner;
                        rr_ptr     <= winner;
                        grant      <= N_MASTERS'(1) << winner;
                        master_sel <= SEL_W'(winner) + SEL_W'(1);
                        busy       <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                        wd_cnt     <= '0;
`endif
                    end
                end
                S_OWN: begin
                    // Release returns to idle; the next grant needs
                    // another edge, which gives the turnaround cycle.
                    if (int'(owner) >= N_MASTERS || !req[owner]) begin
                        state      <= S_IDLE;
                        grant      <= '0;
                        master_sel <= '0;
                        busy       <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
                    end else if (wd_cnt == LIMIT) begin
                        state       <= S_IDLE;
                        grant       <= '0;
                        master_sel  <= '0;
                        busy        <= 1'b0;
                        timeout     <= 1'b1;
                        mask[owner] <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
`endif
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    grant      <= '0;
                    master_sel <= '0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter_n.sv
// tb_i2c_arbiter_n: directed and random checks of i2c_arbiter_n,
// one fixed-priority and one round-robin instance side by side.
module tb_i2c_arbiter_n;

    localparam int TC = 8;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_a = 4'b0;
    logic [3:0] req_b = 4'b0;
    logic [3:0] grant_a, grant_b;
    logic [2:0] sel_a, sel_b;
    logic       busy_a, busy_b, tmo_a, tmo_b;

    int checks = 0;
    int errors = 0;

    wire [8:0] obs_a = {grant_a, sel_a, busy_a, tmo_a};
    wire [8:0] obs_b = {grant_b, sel_b, busy_b, tmo_b};

    always #5 clk = ~clk;

    i2c_arbiter_n #(
        .N_MASTERS(4), .SEL_W(3), .RR_MODE(0), .TIMEOUT_CYCLES(TC)
    ) u_fp (
        .clk(clk), .reset(reset), .req(req_a), .grant(grant_a),
        .master_sel(sel_a), .busy(busy_a), .timeout(tmo_a)
    );

    i2c_arbiter_n #(
        .N_MASTERS(4), .SEL_W(3), .RR_MODE(1), .TIMEOUT_CYCLES(TC)
    ) u_rr (
        .clk(clk), .reset(reset), .req(req_b), .grant(grant_b),
        .master_sel(sel_b), .busy(busy_b), .timeout(tmo_b)
    );

    // Expected {grant, master_sel, busy, timeout} for an owner (-1 = none).
    function automatic logic [8:0] st(int own, logic t);
        if (own < 0) return {4'b0, 3'd0, 1'b0, t};
        return {4'(1 << own), 3'(own + 1), 1'b1, t};
    endfunction

    // Reference model, index 0 = fixed priority, 1 = round robin.
    int         own_m[2];
    int         last_m[2];
    int         held_m[2];
    logic [3:0] mask_m[2];
    logic       tmo_m[2];

    function automatic void mreset();
        for (int k = 0; k < 2; k++) begin
            own_m[k]  = -1;
            last_m[k] = 3;
            held_m[k] = 0;
            mask_m[k] = 4'b0;
            tmo_m[k]  = 1'b0;
        end
    endfunction

    function automatic void mstep(int k, logic [3:0] r);
        logic [3:0] ok;
        int pick;
        ok        = r & ~mask_m[k];
        mask_m[k] = mask_m[k] & r;
        tmo_m[k]  = 1'b0;
        if (own_m[k] >= 0) begin
            held_m[k]++;
            if (!r[own_m[k]]) begin
                own_m[k] = -1;
            end else if (TMO_EN && held_m[k] == TC) begin
                mask_m[k][own_m[k]] = 1'b1;
                own_m[k] = -1;
                tmo_m[k] = 1'b1;
            end
        end else begin
            pick = -1;
            for (int o = 0; o < 4; o++) begin
                int idx;
                idx = (k == 1) ? (last_m[k] + 1 + o) % 4 : o;
                if (pick < 0 && ok[idx]) pick = idx;
            end
            if (pick >= 0) begin
                own_m[k]  = pick;
                last_m[k] = pick;
                held_m[k] = 0;
            end
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_a = 4'b0;
        req_b = 4'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mreset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_a = 4'b1111;
        req_b = 4'b1111;
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== st(-1, 0)) begin
            errors++;
            $display("FAIL reset_fp got %b want %b", obs_a, st(-1, 0));
        end
        checks++;
        if (obs_b !== st(-1, 0)) begin
            errors++;
            $display("FAIL reset_rr got %b want %b", obs_b, st(-1, 0));
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== st(0, 0)) begin
            errors++;
            $display("FAIL first_fp got %b want %b", obs_a, st(0, 0));
        end
        checks++;
        if (obs_b !== st(0, 0)) begin
            errors++;
            $display("FAIL first_rr got %b want %b", obs_b, st(0, 0));
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        req_a = 4'b0110;
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== st(1, 0)) begin
            errors++;
            $display("FAIL fp_win got %b want %b", obs_a, st(1, 0));
        end
        req_a = 4'b0111;
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== st(1, 0)) begin
            errors++;
            $display("FAIL fp_no_preempt got %b want %b", obs_a, st(1, 0));
        end
        req_a = 4'b0100;
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== st(-1, 0)) begin
            errors++;
            $display("FAIL fp_idle got %b want %b", obs_a, st(-1, 0));
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== st(2, 0)) begin
            errors++;
            $display("FAIL fp_next got %b want %b", obs_a, st(2, 0));
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_b = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int w;
            w = i % 4;
            @(posedge clk);
            #1;
            checks++;
            if (obs_b !== st(w, 0)) begin
                errors++;
                $display("FAIL rr_grant%0d got %b want %b", i, obs_b, st(w, 0));
            end
            repeat (2) begin
                @(posedge clk);
                #1;
                checks++;
                if (obs_b !== st(w, 0)) begin
                    errors++;
                    $display("FAIL rr_hold%0d got %b want %b", i, obs_b, st(w, 0));
                end
            end
            req_b[w] = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (obs_b !== st(-1, 0)) begin
                errors++;
                $display("FAIL rr_idle%0d got %b want %b", i, obs_b, st(-1, 0));
            end
            req_b[w] = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_a = 4'b0100;
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== st(2, 0)) begin
            errors++;
            $display("FAIL ar_own got %b want %b", obs_a, st(2, 0));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (obs_a !== st(-1, 0)) begin
            errors++;
            $display("FAIL ar_drop got %b want %b", obs_a, st(-1, 0));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_a = 4'b0;
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req_a = 4'b0011;
        for (int c = 1; c <= TC; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_a !== st(0, 0)) begin
                errors++;
                $display("FAIL tmo_own%0d got %b want %b", c, obs_a, st(0, 0));
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== st(-1, 1)) begin
            errors++;
            $display("FAIL tmo_pulse got %b want %b", obs_a, st(-1, 1));
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== st(1, 0)) begin
            errors++;
            $display("FAIL tmo_next got %b want %b", obs_a, st(1, 0));
        end
        req_a = 4'b0001;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_a !== st(-1, 0)) begin
                errors++;
                $display("FAIL tmo_masked got %b want %b", obs_a, st(-1, 0));
            end
        end
        req_a = 4'b0000;
        @(posedge clk);
        #1;
        req_a = 4'b0001;
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== st(0, 0)) begin
            errors++;
            $display("FAIL tmo_regrant got %b want %b", obs_a, st(0, 0));
        end
    endtask

    task automatic test_release_at_limit();
        do_reset();
        req_a = 4'b0001;
        for (int c = 1; c <= TC; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_a !== st(0, 0)) begin
                errors++;
                $display("FAIL lim_own%0d got %b want %b", c, obs_a, st(0, 0));
            end
        end
        req_a = 4'b0000;
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== st(-1, 0)) begin
            errors++;
            $display("FAIL lim_release got %b want %b", obs_a, st(-1, 0));
        end
        req_a = 4'b0001;
        @(posedge clk);
        #1;
        checks++;
        if (obs_a !== st(0, 0)) begin
            errors++;
            $display("FAIL lim_no_mask got %b want %b", obs_a, st(0, 0));
        end
    endtask
`else
    task automatic test_unbounded();
        do_reset();
        req_a = 4'b0011;
        for (int c = 1; c <= 3 * TC; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_a !== st(0, 0)) begin
                errors++;
                $display("FAIL unb_own%0d got %b want %b", c, obs_a, st(0, 0));
            end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            req_a = req_a ^ (4'($urandom) & 4'($urandom));
            req_b = req_b ^ (4'($urandom) & 4'($urandom));
            @(posedge clk);
            mstep(0, req_a);
            mstep(1, req_b);
            #1;
            checks++;
            if (obs_a !== st(own_m[0], tmo_m[0])) begin
                errors++;
                $display("FAIL rand_fp%0d got %b want %b", n, obs_a, st(own_m[0], tmo_m[0]));
            end
            checks++;
            if (obs_b !== st(own_m[1], tmo_m[1])) begin
                errors++;
                $display("FAIL rand_rr%0d got %b want %b", n, obs_b, st(own_m[1], tmo_m[1]));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        mreset();
        test_reset();
        test_fixed_prio();
        test_round_robin();
        test_async_reset();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
        test_release_at_limit();
`else
        test_unbounded();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
